filter_loader: RTL and testbench
================================

Name: filter_loader

Overview:
- Writer side of the filter buffer load interface: fetches a filter's row words from word-addressed memory and drives the buffer's load/row/data inputs one row at a time.
- Sits between the top-level controller (start/done) and the filter buffer (buf_ld/buf_row/buf_data).
- Each 32-bit row word is packed MSB-first: byte [31:24] is column 0, byte [7:0] is column 3.

Parameters:
- ADDR_W, 16, memory word-address width.
- ROW_STRIDE, 1, word-address increment between consecutive filter rows.
- TIMEOUT, 255, max cycles spent in WAIT before abort (used only with FL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to load a filter; sampled only in IDLE.
- base_addr  in  ADDR_W  word address of filter row 0; latched on accepted start.
- filt_size  in  2  rows to load minus 1 (0..3 means 1..4 rows); latched on accepted start.
- mem_addr  out  ADDR_W  read address; valid while mem_rd=1.
- mem_rd  out  1  read request, one-cycle pulse per row.
- mem_data  in  32  read data; valid when mem_valid=1.
- mem_valid  in  1  read data strobe; sampled only in WAIT.
- buf_ld  out  1  load strobe to the filter buffer, one cycle per row.
- buf_row  out  2  target row index; valid with buf_ld, holds last value otherwise.
- buf_data  out  32  row word; valid with buf_ld.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes (or aborts).
- err  out  1  one-cycle pulse with done on timeout abort; tied 0 without FL_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; mem_addr=0, mem_rd=0, buf_ld=0, buf_row=0, buf_data=0, busy=0, done=0, err=0; row counter=0.
- Reset wins over every other input, including mid-load; a partially loaded buffer is not cleaned up.
- States: IDLE, REQ, WAIT, LOAD, DONE.
- IDLE:
  - start=1 latches base_addr and filt_size, clears the row counter, and moves to REQ.
  - start while busy is ignored (no queuing).
- REQ:
  - mem_rd=1 and mem_addr = base + row*ROW_STRIDE, both registered outputs.
  - Address arithmetic is modulo 2^ADDR_W; wrap-around is allowed.
  - Always moves to WAIT next cycle.
- WAIT:
  - mem_rd=0; holds until mem_valid=1, then captures mem_data and moves to LOAD.
  - mem_valid outside WAIT is ignored, so the earliest usable data arrives the cycle after mem_rd.
- LOAD:
  - buf_ld=1, buf_row=row, buf_data=captured word, for exactly one cycle.
  - If row==filt_size, go to DONE; else row+1 and go to REQ.
- DONE:
  - done=1 for one cycle, then IDLE.
  - busy drops in the IDLE cycle, so start can be accepted in the cycle after done.
- Latency: with 1-cycle memory, rows cost 3 cycles each; N rows finish with done at cycle 3N+1 after the start cycle.
- Ordering: rows are loaded in ascending order 0..filt_size; rows above filt_size are never written.
- filt_size=0 loads only row 0.

Optional Feature:
- FL_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mem_valid, go to DONE with done=1 and err=1 in the same cycle.
  - No buf_ld is issued for the timed-out row; rows already loaded remain.
- FL_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely.
  - err is constant 0.

Test Plan:
- Reset mid-load:
  - Stimulus: assert rst during a WAIT cycle.
  - Required: the next cycle shows all outputs 0 and state IDLE; a new start then runs normally.
- Full 4-row load, 1-cycle memory:
  - Stimulus: start with base_addr=0x0100, filt_size=3; memory returns 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10.
  - Required: mem_addr 0x0100..0x0103; buf_ld pulses at cycles 3, 6, 9, 12 with buf_row 0..3 and matching data; done at cycle 13; busy high cycles 1–13.
- Single-row load with wrap-around address:
  - Stimulus: filt_size=0, base_addr=0xFFFF, ROW_STRIDE=1.
  - Required: exactly one mem_rd at 0xFFFF, one buf_ld with buf_row=0, done at cycle 4.
  - Second check: filt_size=1 at base 0xFFFF reads 0xFFFF then 0x0000.
- Variable memory latency and protocol robustness:
  - Stimulus: mem_valid delayed 5 cycles per row; a spurious mem_valid pulse during LOAD; start=1 held throughout the load.
  - Required: the spurious pulse is ignored; the held start does not restart the load; exactly filt_size+1 buf_ld pulses; the next load begins only after done.
- Timeout (FL_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: memory never asserts mem_valid for row 1.
  - Required: row 0 is loaded; after 8 WAIT cycles, done=1 and err=1 together; no buf_ld for row 1; busy=0 the next cycle.
  - Without the macro: the block stays busy in WAIT and err stays 0.

Source files
------------

// File: rtl/filter_loader_if.sv
// ---------------------------------------------------------------------------
// filter_loader_if
//   Groups the filter-loader signals: the controller request (start /
//   base_addr / filt_size / busy / done / err), the word-addressed memory
//   read port (mem_addr / mem_rd / mem_data / mem_valid) and the filter
//   buffer load port (buf_ld / buf_row / buf_data).
//
//   modport master : the loader itself (drives memory requests and buffer loads)
//   modport slave  : the environment around it (controller, memory, buffer)
// ---------------------------------------------------------------------------
interface filter_loader_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        filt_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_data;
  logic              mem_valid;
  logic              buf_ld;
  logic [1:0]        buf_row;
  logic [31:0]       buf_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, base_addr, filt_size, mem_data, mem_valid,
    output mem_addr, mem_rd, buf_ld, buf_row, buf_data, busy, done, err
  );

  modport slave (
    output start, base_addr, filt_size, mem_data, mem_valid,
    input  mem_addr, mem_rd, buf_ld, buf_row, buf_data, busy, done, err
  );
endinterface

// File: rtl/filter_loader.sv
// ---------------------------------------------------------------------------
// filter_loader
//   Fetches 1..4 filter row words from word-addressed memory and writes them
//   into the filter buffer, one row per buf_ld strobe, ascending row order.
//   Row words are packed MSB-first (byte [31:24] = column 0).
//
// Ports
//   clk, rst : system clock, synchronous active-high reset
//   bus      : filter_loader_if.master
//              start/base_addr/filt_size in, busy/done/err out (controller)
//              mem_addr/mem_rd out, mem_data/mem_valid in     (memory)
//              buf_ld/buf_row/buf_data out                    (filter buffer)
//
// Parameters
//   ADDR_W     : memory word-address width
//   ROW_STRIDE : word-address step between consecutive rows
//   TIMEOUT    : WAIT cycles before abort (only with FL_TIMEOUT_EN)
//
// Build option
//   FL_TIMEOUT_EN : when defined, a read that gets no mem_valid within
//                   TIMEOUT cycles aborts the load with done+err. When not
//                   defined, WAIT holds indefinitely and err is tied 0.
//
// All outputs are registered: they are set on the transition into the state
// in which they are valid.
// ---------------------------------------------------------------------------
module filter_loader #(
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 1,
  parameter int TIMEOUT    = 255
) (
  input logic             clk,
  input logic             rst,
  filter_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_STRIDE);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("filter_loader: TIMEOUT must be at least 1");
  end

  state_t            state;
  logic [1:0]        row;
  logic [1:0]        fsz;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_rd_r;
  logic              buf_ld_r;
  logic [1:0]        buf_row_r;
  logic [31:0]       buf_data_r;
  logic              busy_r;
  logic              done_r;

`ifdef FL_TIMEOUT_EN
  localparam int                WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WLAST  = WCNT_W'(TIMEOUT - 1);

  logic [WCNT_W-1:0] wcnt;
  logic              err_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      row        <= 2'd0;
      fsz        <= 2'd0;
      mem_addr_r <= '0;
      mem_rd_r   <= 1'b0;
      buf_ld_r   <= 1'b0;
      buf_row_r  <= 2'd0;
      buf_data_r <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef FL_TIMEOUT_EN
      wcnt       <= '0;
      err_r      <= 1'b0;
`endif
    end else begin
      // strobes default low; each is raised for exactly one cycle below
      mem_rd_r <= 1'b0;
      buf_ld_r <= 1'b0;
      done_r   <= 1'b0;
`ifdef FL_TIMEOUT_EN
      err_r    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            fsz        <= bus.filt_size;
            row        <= 2'd0;
            mem_addr_r <= bus.base_addr;
            mem_rd_r   <= 1'b1;
            busy_r     <= 1'b1;
            state      <= S_REQ;
          end
        end

        S_REQ: begin
          // read request is on the bus this cycle; data can come from next cycle on
`ifdef FL_TIMEOUT_EN
          wcnt  <= '0;
`endif
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.mem_valid) begin
            buf_ld_r   <= 1'b1;
            buf_row_r  <= row;
            buf_data_r <= bus.mem_data;
            state      <= S_LOAD;
          end
`ifdef FL_TIMEOUT_EN
          else if (wcnt == WLAST) begin
            // abort: rows already written stay in the buffer
            done_r <= 1'b1;
            err_r  <= 1'b1;
            state  <= S_DONE;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
`endif
        end

        S_LOAD: begin
          if (row == fsz) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            // address wraps modulo 2^ADDR_W
            row        <= row + 2'd1;
            mem_addr_r <= mem_addr_r + STRIDE;
            mem_rd_r   <= 1'b1;
            state      <= S_REQ;
          end
        end

        S_DONE: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.buf_ld   = buf_ld_r;
  assign bus.buf_row  = buf_row_r;
  assign bus.buf_data = buf_data_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
`ifdef FL_TIMEOUT_EN
  assign bus.err      = err_r;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_filter_loader.sv
// ---------------------------------------------------------------------------
// tb_filter_loader
//   The whole run is planned up front: for every cycle k the planner fills
//   the inputs to drive during cycle k (d_*) and the outputs the loader must
//   show during cycle k (e_*). A load's timeline follows from the timing
//   rules: read request one cycle after start, data after the chosen memory
//   latency, buffer write the cycle after data, next request the cycle
//   after that, done one cycle after the last write.
// ---------------------------------------------------------------------------
module tb_filter_loader;
  localparam int AW  = 16;
  localparam int TMO = 8;
  localparam int NC  = 4096;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  filter_loader_if #(.ADDR_W(AW)) bus ();

  filter_loader #(
    .ADDR_W    (AW),
    .ROW_STRIDE(1),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inputs for cycle k
  bit          d_rst [NC];
  bit          d_start [NC];
  bit          d_valid [NC];
  logic [15:0] d_base [NC];
  logic [1:0]  d_fsz [NC];
  logic [31:0] d_mdata [NC];

  // required outputs for cycle k
  bit          e_en [NC];
  bit          e_zero [NC];
  bit          e_busy [NC];
  bit          e_rd [NC];
  bit          e_ld [NC];
  bit          e_done [NC];
  bit          e_err [NC];
  logic [15:0] e_addr [NC];
  logic [1:0]  e_row [NC];
  logic [31:0] e_data [NC];

  int         pc;
  logic [1:0] prow;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, required %h", nm, k, act, expv);
    end
  endtask

  task automatic state_at(input int k, input bit busy);
    e_en[k]   = 1'b1;
    e_busy[k] = busy;
    e_rd[k]   = 1'b0;
    e_ld[k]   = 1'b0;
    e_done[k] = 1'b0;
    e_err[k]  = 1'b0;
    e_row[k]  = prow;
  endtask

  task automatic zero_at(input int k);
    prow = 2'd0;
    state_at(k, 1'b0);
    e_zero[k] = 1'b1;
    e_addr[k] = 16'h0000;
    e_data[k] = 32'h0;
  endtask

  // stray mem_valid on a cycle where the loader must ignore it
  task automatic noise(input int k);
    if ($urandom_range(1, 0) == 1) begin
      d_valid[k] = 1'b1;
      d_mdata[k] = $urandom;
    end
  endtask

  task automatic plan_idle(input int n);
    for (int i = 0; i < n; i++) begin
      state_at(pc, 1'b0);
      noise(pc);
      pc++;
    end
  endtask

  // stall_row >= 0: that row's memory never answers; after stall_len WAIT
  // cycles rst is asserted, unless the timeout aborts the load first.
  task automatic plan_load(input logic [15:0] base, input logic [1:0] fsz,
                           input logic [31:0] dw [4], input int lmin, input int lmax,
                           input bit noisy, input int stall_row, input int stall_len);
    int s, c, lat, nw;
    logic [15:0] a;
    s = pc;
    a = base;
    state_at(s, 1'b0);
    d_start[s] = 1'b1;
    d_base[s]  = base;
    d_fsz[s]   = fsz;
    c = s + 1;
    for (int r = 0; r <= int'(fsz); r++) begin
      state_at(c, 1'b1);
      e_rd[c]   = 1'b1;
      e_addr[c] = a;
      if (noisy) begin d_start[c] = 1'b1; noise(c); end
      if (r == stall_row) begin
        nw = stall_len;
`ifdef FL_TIMEOUT_EN
        if (nw > TMO) nw = TMO;
`endif
        for (int w = 1; w <= nw; w++) begin
          state_at(c + w, 1'b1);
          if (noisy) d_start[c + w] = 1'b1;
        end
`ifdef FL_TIMEOUT_EN
        if (stall_len >= TMO) begin
          state_at(c + nw + 1, 1'b1);
          e_done[c + nw + 1] = 1'b1;
          e_err[c + nw + 1]  = 1'b1;
          pc = c + nw + 2;
          return;
        end
`endif
        d_rst[c + nw] = 1'b1;
        zero_at(c + nw + 1);
        pc = c + nw + 1;
        return;
      end
      lat = $urandom_range(lmax, lmin);
      for (int w = 1; w <= lat; w++) begin
        state_at(c + w, 1'b1);
        if (noisy) d_start[c + w] = 1'b1;
      end
      d_valid[c + lat] = 1'b1;
      d_mdata[c + lat] = dw[r];
      prow = 2'(r);
      state_at(c + lat + 1, 1'b1);
      e_ld[c + lat + 1]   = 1'b1;
      e_data[c + lat + 1] = dw[r];
      if (noisy) begin d_start[c + lat + 1] = 1'b1; noise(c + lat + 1); end
      c = c + lat + 2;
      a = a + 16'd1;
    end
    state_at(c, 1'b1);
    e_done[c] = 1'b1;
    if (noisy) begin d_start[c] = 1'b1; noise(c); end
    pc = c + 1;
  endtask

  task automatic rand_words(output logic [31:0] dw [4]);
    for (int i = 0; i < 4; i++) dw[i] = $urandom;
  endtask

  task automatic apply(input int k);
    rst           = d_rst[k];
    bus.start     = d_start[k];
    bus.base_addr = d_base[k];
    bus.filt_size = d_fsz[k];
    bus.mem_valid = d_valid[k];
    bus.mem_data  = d_mdata[k];
  endtask

  // compare process
  always @(negedge clk) begin
    if (cyc < NC && e_en[cyc]) begin
      chk("busy", cyc, 32'(bus.busy), 32'(e_busy[cyc]));
      chk("mem_rd", cyc, 32'(bus.mem_rd), 32'(e_rd[cyc]));
      chk("buf_ld", cyc, 32'(bus.buf_ld), 32'(e_ld[cyc]));
      chk("done", cyc, 32'(bus.done), 32'(e_done[cyc]));
      chk("err", cyc, 32'(bus.err), 32'(e_err[cyc]));
      chk("buf_row", cyc, 32'(bus.buf_row), 32'(e_row[cyc]));
      if (e_rd[cyc] || e_zero[cyc]) chk("mem_addr", cyc, 32'(bus.mem_addr), 32'(e_addr[cyc]));
      if (e_ld[cyc] || e_zero[cyc]) chk("buf_data", cyc, bus.buf_data, e_data[cyc]);
    end
  end

  initial begin
    logic [31:0] dw [4];
    int s, nrd, last;
    for (int k = 0; k < NC; k++) begin
      d_base[k]  = 16'($urandom);
      d_fsz[k]   = 2'($urandom);
      d_mdata[k] = $urandom;
    end
    prow = 2'd0;

    // reset for two cycles
    d_rst[0] = 1'b1;
    d_rst[1] = 1'b1;
    zero_at(1);
    zero_at(2);
    pc = 2;
    plan_idle(2);

    // full 4-row load, 1-cycle memory
    dw = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    s = pc;
    plan_load(16'h0100, 2'd3, dw, 1, 1, 1'b0, -1, 0);
    chk("pin_addr0", s, 32'(e_addr[s + 1]), 32'h0100);
    chk("pin_addr3", s, 32'(e_addr[s + 10]), 32'h0103);
    chk("pin_ld3", s, 32'(e_ld[s + 3]), 32'd1);
    chk("pin_ld12_row", s, 32'(e_row[s + 12]), 32'd3);
    chk("pin_ld6_data", s, e_data[s + 6], 32'h05060708);
    chk("pin_done13", s, 32'(e_done[s + 13]), 32'd1);
    chk("pin_busy14", s, 32'(e_busy[s + 14]), 32'd0);
    plan_idle(1);

    // single row at the top of the address space
    rand_words(dw);
    s = pc;
    plan_load(16'hFFFF, 2'd0, dw, 1, 1, 1'b0, -1, 0);
    nrd = 0;
    for (int k = s; k < pc; k++) nrd += int'(e_rd[k]);
    chk("pin_one_rd", s, 32'(nrd), 32'd1);
    chk("pin_wrap_addr", s, 32'(e_addr[s + 1]), 32'hFFFF);
    chk("pin_done4", s, 32'(e_done[s + 4]), 32'd1);

    // two rows wrapping through address 0
    rand_words(dw);
    s = pc;
    plan_load(16'hFFFF, 2'd1, dw, 1, 1, 1'b0, -1, 0);
    chk("pin_wrap_next", s, 32'(e_addr[s + 4]), 32'h0000);
    plan_idle(2);

    // slow memory, held start, stray mem_valid; next load right after done
    rand_words(dw);
    plan_load(16'($urandom), 2'd3, dw, 5, 5, 1'b1, -1, 0);
    rand_words(dw);
    plan_load(16'($urandom), 2'd1, dw, 1, 2, 1'b0, -1, 0);
    plan_idle(1);

    // reset while waiting for row 1, then a clean load
    rand_words(dw);
    plan_load(16'h2000, 2'd2, dw, 1, 2, 1'b0, 1, 3);
    plan_idle(1);
    rand_words(dw);
    plan_load(16'h3000, 2'd3, dw, 1, 3, 1'b0, -1, 0);

    // randomized loads
    for (int t = 0; t < 30; t++) begin
      plan_idle($urandom_range(2, 0));
      rand_words(dw);
      plan_load(16'($urandom), 2'($urandom), dw, 1, $urandom_range(4, 1),
                1'($urandom_range(1, 0)), -1, 0);
    end

    // memory never answers row 1: timeout abort, or a permanent stall
    plan_idle(1);
    rand_words(dw);
    plan_load(16'h4000, 2'd3, dw, 1, 2, 1'b0, 1, 40);
    plan_idle(2);
    rand_words(dw);
    plan_load(16'h5000, 2'd2, dw, 1, 2, 1'b0, -1, 0);
    plan_idle(3);
    last = pc;

    apply(0);
    while (cyc < last) begin
      @(negedge clk);
      if (cyc < NC) apply(cyc);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
